muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The unit SHALL have one clock and a synchronous, active-low reset.
REQ-002 Port list:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- A  in  32  operand A, from the same forwarded operand bus that drives the EX ALU.
- B  in  32  operand B, from the same forwarded operand bus that drives the EX ALU.
- MDOp_EX  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- Start  in  1  issue strobe for MDOp_EX.
- Busy  out  1  an operation is in flight; the hazard unit stalls every MD instruction while Busy=1.
- HI  out  32  HI register; the EX result mux reads it for mfhi.
- LO  out  32  LO register; the EX result mux reads it for mflo.

Function
REQ-003 HI, LO and Busy SHALL all be registered outputs.
REQ-004 An operation SHALL be accepted only on an edge where Start=1, Busy=0 and MDOp_EX is in 1..6.
- Start while Busy=1 is ignored, with no side effect.
- Start with op 0 or 7 is ignored.
REQ-005 mthi SHALL write A to HI at the accepting edge. mtlo SHALL write A to LO at the accepting edge. Neither asserts Busy.
REQ-006 mult/multu/div/divu SHALL capture A, B and the op at the accepting edge (edge k) and set Busy=1 after edge k.
REQ-007 At edge k+N the unit SHALL write HI/LO and clear Busy, giving exactly N cycles of Busy. N=5 for mult/multu, N=10 for div/divu.
REQ-008 Operand changes on A and B after edge k SHALL NOT affect the result.
REQ-009 HI/LO SHALL hold their previous values throughout Busy=1.
REQ-010 mult SHALL compute {HI,LO} = 64-bit signed A*B. multu SHALL compute {HI,LO} = 64-bit unsigned A*B.
REQ-011 div SHALL produce LO = signed quotient truncated toward zero, and HI = remainder carrying the sign of the dividend.
REQ-012 divu SHALL produce LO = unsigned quotient and HI = unsigned remainder.
REQ-013 Divide by zero (B=0) SHALL produce HI=A and LO=32'hFFFFFFFF, for both div and divu.
REQ-014 div of 32'h80000000 by 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0, with no exception.
REQ-015 State machine:
- IDLE -> MUL on accepted mult/multu.
- IDLE -> DIV on accepted div/divu.
- MUL/DIV -> IDLE when the cycle counter reaches N-1.
- The counter is 4 bits wide and cleared on entry to MUL/DIV.
REQ-016 A Start that coincides with the completing edge SHALL be ignored, because Busy is still 1 on that edge; it is accepted on the following edge.

Reset
REQ-017 With rst_n=0 at a clock edge, the unit SHALL set HI=0, LO=0, Busy=0, state=IDLE and counter=0.
REQ-018 Reset mid-operation SHALL abort the operation; no partial result is written to HI/LO.
REQ-019 rst_n SHALL take priority over Start on the same edge.

Configuration
REQ-020 Macro MULDIV_DIV_EN defined: div/divu SHALL be implemented as in REQ-011..014.
REQ-021 Macro MULDIV_DIV_EN undefined: the divider logic and the DIV state SHALL be absent, and div/divu SHALL be ignored exactly like op 0 (Busy stays 0, HI/LO unchanged).

Structure
REQ-022 Package muldiv_pkg SHALL hold:
- the MDOp_EX encodings;
- the state typedef (IDLE, MUL, DIV);
- constants MUL_LAT=5 and DIV_LAT=10.
REQ-023 The divider SHALL be the sub-module md_div: combinational 32-bit signed/unsigned divide with the divide-by-zero and overflow handling of REQ-013..014.
REQ-024 md_div SHALL be instantiated only under MULDIV_DIV_EN. The multiply SHALL be inline.

Verification
REQ-025 mult, A=32'hFFFFFFFF, B=2 -> Busy=1 for exactly 5 cycles, then HI=32'hFFFFFFFF and LO=32'hFFFFFFFE. multu with the same operands -> HI=1, LO=32'hFFFFFFFE.
REQ-026 div, A=-7, B=2 -> Busy for 10 cycles, then LO=32'hFFFFFFFD and HI=32'hFFFFFFFF. divu, A=7, B=2 -> LO=3, HI=1.
REQ-027 Boundary operands:
- div A=5, B=0 -> HI=5, LO=32'hFFFFFFFF.
- div A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
REQ-028 Ignored requests:
- mult issued, then mthi A=32'h1234 during Busy -> HI equals the product and 32'h1234 is never seen.
- Start on the completing edge -> accepted one cycle later.
- mtlo A=32'hABCD while idle -> LO=32'hABCD after one edge, Busy stays 0.
REQ-029 div issued, rst_n=0 in the 3rd Busy cycle -> after that edge Busy=0, HI=0, LO=0, and no late write to HI/LO occurs.
REQ-030 Build without MULDIV_DIV_EN, issue div A=9, B=3 -> Busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings, FSM states and latencies for the multiply/divide unit.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } md_state_e;

  localparam int        DATA_W  = 32;
  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;

endpackage

// File: rtl/md_div.sv
// Combinational 32-bit signed/unsigned divider with MIPS-style divide-by-zero
// (HI=dividend, LO=all ones) and INT_MIN/-1 overflow (LO=INT_MIN, HI=0) handling.
module md_div
  import muldiv_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              is_signed,
  output logic [DATA_W-1:0] quo,
  output logic [DATA_W-1:0] rem
);

  logic signed [DATA_W-1:0] sa;
  logic signed [DATA_W-1:0] sb;
  logic                     ovf;

  assign sa  = $signed(a);
  assign sb  = $signed(b);
  assign ovf = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  // Signed / and % already truncate toward zero with remainder following the dividend.
  always_comb begin
    quo = '1;
    rem = a;
    if (b == '0) begin
      quo = '1;
      rem = a;
    end else if (ovf) begin
      quo = 32'h8000_0000;
      rem = '0;
    end else if (is_signed) begin
      quo = sa / sb;
      rem = sa % sb;
    end else begin
      quo = a / b;
      rem = a % b;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit (mult 5 cycles, div 10 cycles).
// Define MULDIV_DIV_EN to build the divider; otherwise div/divu are ignored.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDOp_EX,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  md_state_e state, state_nxt;
  md_op_e    op;
  logic [3:0]        cnt, cnt_nxt;
  logic              busy_nxt;
  logic [DATA_W-1:0] hi_nxt, lo_nxt;
  logic              capture;
  logic              accept;

  logic [DATA_W-1:0]   a_p0, b_p0;
  logic                signed_p0;
  logic signed [63:0]  a_ext, b_ext, prod;

  assign op     = md_op_e'(MDOp_EX);
  assign accept = Start && !Busy;

  // Extending both operands to 64 bits makes one multiplier serve mult and multu.
  assign a_ext = $signed({{32{signed_p0 & a_p0[31]}}, a_p0});
  assign b_ext = $signed({{32{signed_p0 & b_p0[31]}}, b_p0});
  assign prod  = a_ext * b_ext;

`ifdef MULDIV_DIV_EN
  logic [DATA_W-1:0] quo, rem;

  md_div u_div (
    .a         (a_p0),
    .b         (b_p0),
    .is_signed (signed_p0),
    .quo       (quo),
    .rem       (rem)
  );
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = Busy;
    hi_nxt    = HI;
    lo_nxt    = LO;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (accept) begin
          case (op)
            MD_MULT, MD_MULTU: begin
              state_nxt = MUL;
              cnt_nxt   = '0;
              busy_nxt  = 1'b1;
              capture   = 1'b1;
            end
`ifdef MULDIV_DIV_EN
            MD_DIV, MD_DIVU: begin
              state_nxt = DIV;
              cnt_nxt   = '0;
              busy_nxt  = 1'b1;
              capture   = 1'b1;
            end
`endif
            MD_MTHI: hi_nxt = A;
            MD_MTLO: lo_nxt = A;
            default: ;
          endcase
        end
      end
      MUL: begin
        if (cnt == MUL_LAT - 4'd1) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          hi_nxt    = prod[63:32];
          lo_nxt    = prod[31:0];
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`ifdef MULDIV_DIV_EN
      DIV: begin
        if (cnt == DIV_LAT - 4'd1) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          hi_nxt    = rem;
          lo_nxt    = quo;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      Busy  <= busy_nxt;
      HI    <= hi_nxt;
      LO    <= lo_nxt;
    end
  end

  // Operand capture stage: frozen for the whole operation so forwarding changes cannot leak in.
  always_ff @(posedge clk) begin
    if (capture) begin
      a_p0      <= A;
      b_p0      <= B;
      signed_p0 <= (op == MD_MULT) || (op == MD_DIV);
    end
  end

endmodule
